fsb_trace_replay: RTL and testbench

- Synthesizable trace-replay engine that drives stimulus into a DUT and checks the DUT's responses.
- Commands come from an external combinational trace ROM.
- Each ROM word is a 4-bit opcode followed by a ring_width_p-bit payload.
- Sends payloads over a valid/yumi output channel, receives and compares data over a valid/ready input channel, and reports done/error.

---
 rtl/fsb_trace_replay_if.sv | 22 ++
 rtl/fsb_trace_replay.sv | 111 +++++++++++
 tb/tb_fsb_trace_replay.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsb_trace_replay_if.sv
// Handshake channels between the trace-replay engine and the DUT it drives:
// a valid/yumi send channel and a valid/ready receive channel.
interface fsb_trace_replay_if #(
    parameter int ring_width_p = 80
) ();
    logic                    v_i;
    logic [ring_width_p-1:0] data_i;
    logic                    ready_o;
    logic                    v_o;
    logic [ring_width_p-1:0] data_o;
    logic                    yumi_i;

    // master is the replay engine, slave is the DUT side
    modport master (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o
    );
    modport slave (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o
    );
endinterface

// File: rtl/fsb_trace_replay.sv
// Trace-replay engine: walks a combinational trace ROM, sends payloads to a DUT,
// compares the DUT's responses and reports sticky done/error.
//
// op   | meaning
// 0000 | nop, one cycle
// 0001 | send payload, completes on yumi
// 0010 | receive and compare against payload
// 0011 | done, halt replay
// 0100 | finish, same as done
// 0101 | wait payload[15:0]+2 cycles
// else | illegal, flag error and skip
module fsb_trace_replay #(
    parameter int ring_width_p     = 80,
    parameter int rom_addr_width_p = 6
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        en_i,
    fsb_trace_replay_if.master          chan,
    output logic [rom_addr_width_p-1:0] rom_addr_o,
    input  logic [ring_width_p+3:0]     rom_data_i,
    output logic                        done_o,
    output logic                        error_o
);
    typedef enum logic [3:0] {
        op_nop    = 4'h0,
        op_send   = 4'h1,
        op_recv   = 4'h2,
        op_done   = 4'h3,
        op_finish = 4'h4,
        op_wait   = 4'h5
    } op_e;

    op_e                         op;
    logic [ring_width_p-1:0]     payload;
    logic [15:0]                 wait_load;
    logic [15:0]                 wait_cnt;
    logic [15:0]                 wait_cnt_n;
    logic                        loaded;
    logic                        loaded_n;
    logic [rom_addr_width_p-1:0] addr_n;
    logic                        done_n;
    logic                        error_n;
    logic                        active;
    logic                        complete;

    assign op        = op_e'(rom_data_i[ring_width_p+3 -: 4]);
    assign payload   = rom_data_i[ring_width_p-1:0];
    assign wait_load = 16'(payload);

    // handshakes are offered only while replay is live, never during reset
    assign active       = en_i & ~done_o & ~reset_i;
    assign chan.v_o     = active & (op == op_send);
    assign chan.ready_o = active & (op == op_recv);
    assign chan.data_o  = payload;

    always_comb begin
        addr_n     = rom_addr_o;
        done_n     = done_o;
        error_n    = error_o;
        wait_cnt_n = wait_cnt;
        loaded_n   = loaded;
        complete   = 1'b0;
        if (active) begin
            case (op)
                op_nop: complete = 1'b1;
                op_send: complete = chan.yumi_i;
                op_recv: begin
                    if (chan.v_i) begin
                        complete = 1'b1;
                        if (chan.data_i != payload) error_n = 1'b1;
                    end
                end
                op_done, op_finish: done_n = 1'b1;
                op_wait: begin
                    // first cycle loads, then count down to terminal count
                    if (!loaded) begin
                        wait_cnt_n = wait_load;
                        loaded_n   = 1'b1;
                    end else if (wait_cnt == 16'd0) begin
                        loaded_n = 1'b0;
                        complete = 1'b1;
                    end else begin
                        wait_cnt_n = wait_cnt - 16'd1;
                    end
                end
                default: begin
                    error_n  = 1'b1;
                    complete = 1'b1;
                end
            endcase
            if (complete) addr_n = rom_addr_o + rom_addr_width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rom_addr_o <= '0;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            wait_cnt   <= '0;
            loaded     <= 1'b0;
        end else begin
            rom_addr_o <= addr_n;
            done_o     <= done_n;
            error_o    <= error_n;
            wait_cnt   <= wait_cnt_n;
            loaded     <= loaded_n;
        end
    end
endmodule

// File: tb/tb_fsb_trace_replay.sv
// Bench for fsb_trace_replay: directed scenarios plus random trace programs
// checked against a transaction-level expectation of sends, receives and timing.
module tb_fsb_trace_replay;
    localparam int rw = 8;
    localparam int aw = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0;
    always #5 clk = ~clk;

    fsb_trace_replay_if #(.ring_width_p(rw)) chan ();
    logic [aw-1:0] rom_addr;
    logic [rw+3:0] rom_data;
    logic          done;
    logic          error;
    logic [rw+3:0] rom [64];
    assign rom_data = rom[rom_addr];

    fsb_trace_replay #(.ring_width_p(rw), .rom_addr_width_p(aw)) dut (
        .clk_i(clk), .reset_i(reset), .en_i(en), .chan(chan),
        .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .done_o(done), .error_o(error)
    );

    // second instance with a 2-bit address for the wrap check, ROM all nop
    fsb_trace_replay_if #(.ring_width_p(rw)) chan_w ();
    logic          reset_w = 1'b1;
    logic [1:0]    addr_w;
    logic [rw+3:0] rom_w;
    logic          done_w;
    logic          error_w;
    assign rom_w = '0;

    fsb_trace_replay #(.ring_width_p(rw), .rom_addr_width_p(2)) dut_w (
        .clk_i(clk), .reset_i(reset_w), .en_i(1'b1), .chan(chan_w),
        .rom_addr_o(addr_w), .rom_data_i(rom_w),
        .done_o(done_w), .error_o(error_w)
    );

    int n_assert = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = {4'h3, 8'h00};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b1;
        chan.yumi_i = 1'b0;
        chan.v_i = 1'b0;
        chan.data_i = '0;
        cyc();
        reset = 1'b0;
    endtask

    // random-program state
    logic [3:0]    prog_op [64];
    int            prog_pl [64];
    logic [rw-1:0] send_q [$];
    logic [rw-1:0] recv_q [$];
    logic          exp_err;
    int            n_cmd;
    int            send_idx;
    int            recv_idx;
    int            dur;
    int            cyc_n;
    logic [aw-1:0] a_prev;
    logic          en_prev;
    int            r;
    logic [rw-1:0] pl;
    logic [3:0]    op;

    initial begin
        chan.v_i = 1'b0;
        chan.data_i = '0;
        chan.yumi_i = 1'b0;
        chan_w.v_i = 1'b0;
        chan_w.data_i = '0;
        chan_w.yumi_i = 1'b0;
        clear_rom();

        // send then receive, both matching
        rom[0] = {4'h1, 8'hA5};
        rom[1] = {4'h2, 8'h3C};
        rom[2] = {4'h3, 8'h77};
        reset = 1'b1;
        en = 1'b1;
        #1;
        check("rst_v", chan.v_o, 1'b0);
        check("rst_rdy", chan.ready_o, 1'b0);
        do_reset();
        check("rst_addr", rom_addr, 0);
        check("rst_done", done, 1'b0);
        check("rst_err", error, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            chan.yumi_i = (c == 3);
            #1;
            check("t1_v", chan.v_o, 1'b1);
            check("t1_data", chan.data_o, 8'hA5);
            check("t1_rdy0", chan.ready_o, 1'b0);
            cyc();
        end
        chan.yumi_i = 1'b0;
        for (int c = 4; c <= 5; c++) begin
            chan.v_i = (c == 5);
            chan.data_i = (c == 5) ? 8'h3C : 8'h00;
            #1;
            check("t1_rdy", chan.ready_o, 1'b1);
            check("t1_vlow", chan.v_o, 1'b0);
            check("t1_addr1", rom_addr, 1);
            cyc();
        end
        chan.v_i = 1'b0;
        #1;
        check("t1_addr2", rom_addr, 2);
        check("t1_rdy_off", chan.ready_o, 1'b0);
        check("t1_notdone", done, 1'b0);
        cyc();
        check("t1_done", done, 1'b1);
        check("t1_err", error, 1'b0);
        repeat (3) cyc();
        check("t1_hold", rom_addr, 2);

        // receive mismatch
        clear_rom();
        rom[0] = {4'h2, 8'h11};
        rom[1] = {4'h3, 8'h00};
        do_reset();
        chan.v_i = 1'b1;
        chan.data_i = 8'h12;
        #1;
        check("t2_rdy", chan.ready_o, 1'b1);
        cyc();
        chan.v_i = 1'b0;
        check("t2_err", error, 1'b1);
        check("t2_addr", rom_addr, 1);
        cyc();
        check("t2_done", done, 1'b1);
        cyc();
        check("t2_err_sticky", error, 1'b1);

        // wait-cycles: payload 3 then payload 0
        clear_rom();
        rom[0] = {4'h5, 8'h03};
        rom[1] = {4'h1, 8'h55};
        do_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t3_wait3_v0", chan.v_o, 1'b0);
            cyc();
        end
        #1;
        check("t3_wait3_v1", chan.v_o, 1'b1);
        check("t3_wait3_data", chan.data_o, 8'h55);
        rom[0] = {4'h5, 8'h00};
        do_reset();
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t3_wait0_v0", chan.v_o, 1'b0);
            cyc();
        end
        #1;
        check("t3_wait0_v1", chan.v_o, 1'b1);

        // enable stall during a send
        clear_rom();
        rom[0] = {4'h1, 8'h5A};
        rom[1] = {4'h3, 8'h00};
        do_reset();
        #1;
        check("t4_v_pre", chan.v_o, 1'b1);
        en = 1'b0;
        for (int s = 0; s < 4; s++) begin
            chan.yumi_i = (s == 1);
            #1;
            check("t4_v_stall", chan.v_o, 1'b0);
            check("t4_addr_stall", rom_addr, 0);
            cyc();
        end
        en = 1'b1;
        chan.yumi_i = 1'b0;
        #1;
        check("t4_v_resume", chan.v_o, 1'b1);
        check("t4_data_resume", chan.data_o, 8'h5A);
        check("t4_addr_resume", rom_addr, 0);
        chan.yumi_i = 1'b1;
        cyc();
        chan.yumi_i = 1'b0;
        check("t4_addr_adv", rom_addr, 1);

        // illegal opcode, then reset clears everything
        clear_rom();
        rom[0] = {4'hF, 8'h9D};
        rom[1] = {4'h0, 8'h42};
        rom[2] = {4'h3, 8'h00};
        do_reset();
        cyc();
        check("t5_err", error, 1'b1);
        check("t5_addr1", rom_addr, 1);
        check("t5_notdone", done, 1'b0);
        cyc();
        check("t5_addr2", rom_addr, 2);
        cyc();
        check("t5_done", done, 1'b1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("t5_rst_addr", rom_addr, 0);
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_err", error, 1'b0);

        // address wrap on the 2-bit instance
        reset_w = 1'b1;
        cyc();
        reset_w = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("t6_wrap", addr_w, k % 4);
            cyc();
        end
        check("t6_err", error_w, 1'b0);

        // random programs with random DUT behaviour and enable toggling
        for (int it = 0; it < 4; it++) begin
            clear_rom();
            send_q.delete();
            recv_q.delete();
            exp_err = 1'b0;
            n_cmd = $urandom_range(12, 30);
            for (int i = 0; i < n_cmd; i++) begin
                r = $urandom_range(0, 9);
                pl = 8'($urandom);
                if (r <= 1) op = 4'h0;
                else if (r <= 4) begin
                    op = 4'h1;
                    send_q.push_back(pl);
                end else if (r <= 7) begin
                    op = 4'h2;
                    if ($urandom_range(0, 4) == 0) begin
                        recv_q.push_back(pl ^ 8'($urandom_range(1, 255)));
                        exp_err = 1'b1;
                    end else begin
                        recv_q.push_back(pl);
                    end
                end else if (r == 8) begin
                    op = 4'h5;
                    pl = 8'($urandom_range(0, 6));
                end else begin
                    op = 4'($urandom_range(6, 15));
                    exp_err = 1'b1;
                end
                prog_op[i] = op;
                prog_pl[i] = int'(pl);
                rom[i] = {op, pl};
            end
            rom[n_cmd] = {($urandom_range(0, 1) == 1) ? 4'h3 : 4'h4, 8'($urandom)};

            do_reset();
            send_idx = 0;
            recv_idx = 0;
            dur = 0;
            cyc_n = 0;
            while (!done && cyc_n < 4000) begin
                en = ($urandom_range(0, 7) != 0);
                chan.yumi_i = ($urandom_range(0, 2) == 0);
                chan.v_i = ($urandom_range(0, 1) == 1);
                chan.data_i = (recv_idx < recv_q.size()) ? recv_q[recv_idx] : 8'hEE;
                #1;
                if (!en) begin
                    check("rnd_v_off", chan.v_o, 1'b0);
                    check("rnd_rdy_off", chan.ready_o, 1'b0);
                end
                if (chan.v_o && chan.yumi_i) begin
                    if (send_idx < send_q.size())
                        check("rnd_send_data", chan.data_o, send_q[send_idx]);
                    else
                        check("rnd_extra_send", send_idx, send_q.size() - 1);
                    send_idx++;
                end
                if (chan.ready_o && chan.v_i) recv_idx++;
                if (en) dur++;
                a_prev = rom_addr;
                en_prev = en;
                cyc();
                cyc_n++;
                if (!en_prev) begin
                    check("rnd_addr_hold", rom_addr, a_prev);
                end else if (rom_addr != a_prev) begin
                    if (prog_op[a_prev] == 4'h5)
                        check("rnd_wait_len", dur, prog_pl[a_prev] + 2);
                    else if (prog_op[a_prev] == 4'h0 || prog_op[a_prev] >= 4'h6)
                        check("rnd_1cyc_len", dur, 1);
                    dur = 0;
                end
            end
            check("rnd_done", done, 1'b1);
            check("rnd_final_addr", rom_addr, n_cmd);
            check("rnd_error", error, exp_err);
            check("rnd_n_sends", send_idx, send_q.size());
            check("rnd_n_recvs", recv_idx, recv_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
